// File: rtl/enc8b10b_pkg.sv
// Shared constants and types for the multi-lane 8b/10b encoder.
package enc8b10b_pkg;

   localparam int unsigned SYM_W  = 10;
   localparam int unsigned BYTE_W = 9;

   // {k, d[7:0]} for the comma character
   localparam logic [BYTE_W-1:0] K28_5 = 9'h1BC;

   // K28.5 as it leaves the encoder, {j,h,g,f,i,e,d,c,b,a}
   localparam logic [SYM_W-1:0] K28_5_RDN = 10'h17C;
   localparam logic [SYM_W-1:0] K28_5_RDP = 10'h283;

   typedef struct packed {
      logic       k;
      logic [7:0] d;
   } lane_sym_t;

endpackage

// File: rtl/enc8b10b_lane.sv
// One 8b/10b lane: combinational 5b/6b + 3b/4b encode with disparity in/out.
// Illegal K inputs go through the same equations and only raise illegal_k.
module enc8b10b_lane
   import enc8b10b_pkg::*;
(
   input  lane_sym_t        sym,
   input  logic             disp_in,
   output logic [SYM_W-1:0] code,
   output logic             disp_out,
   output logic             illegal_k
);

   logic [4:0] x;
   logic [2:0] y;
   logic       k28;
   logic [5:0] c6_rdn;  // {a,b,c,d,e,i} as used at RD-
   logic [3:0] c4_rdn;  // {f,g,h,j}
   logic [5:0] c6;
   logic [3:0] c4;
   logic       unbal6;
   logic       unbal4;
   logic       comp6;
   logic       comp4;
   logic       disp6;
   logic       use_a7;

   assign x   = sym.d[4:0];
   assign y   = sym.d[7:5];
   assign k28 = sym.k && (x == 5'd28);

   // 5b/6b lookup, RD- column
   always_comb begin
      c6_rdn = 6'b000000;
      unique case (x)
         5'd0:  c6_rdn = 6'b100111;   5'd1:  c6_rdn = 6'b011101;
         5'd2:  c6_rdn = 6'b101101;   5'd3:  c6_rdn = 6'b110001;
         5'd4:  c6_rdn = 6'b110101;   5'd5:  c6_rdn = 6'b101001;
         5'd6:  c6_rdn = 6'b011001;   5'd7:  c6_rdn = 6'b111000;
         5'd8:  c6_rdn = 6'b111001;   5'd9:  c6_rdn = 6'b100101;
         5'd10: c6_rdn = 6'b010101;   5'd11: c6_rdn = 6'b110100;
         5'd12: c6_rdn = 6'b001101;   5'd13: c6_rdn = 6'b101100;
         5'd14: c6_rdn = 6'b011100;   5'd15: c6_rdn = 6'b010111;
         5'd16: c6_rdn = 6'b011011;   5'd17: c6_rdn = 6'b100011;
         5'd18: c6_rdn = 6'b010011;   5'd19: c6_rdn = 6'b110010;
         5'd20: c6_rdn = 6'b001011;   5'd21: c6_rdn = 6'b101010;
         5'd22: c6_rdn = 6'b011010;   5'd23: c6_rdn = 6'b111010;
         5'd24: c6_rdn = 6'b110011;   5'd25: c6_rdn = 6'b100110;
         5'd26: c6_rdn = 6'b010110;   5'd27: c6_rdn = 6'b110110;
         5'd28: c6_rdn = 6'b001110;   5'd29: c6_rdn = 6'b101110;
         5'd30: c6_rdn = 6'b011110;   5'd31: c6_rdn = 6'b101011;
         default: c6_rdn = 6'b000000;
      endcase
      if (k28) c6_rdn = 6'b001111;
   end

   // Unbalanced 6b codes flip disparity; D.7 is balanced but still alternates
   assign unbal6 = k28 || (x inside {5'd0, 5'd1, 5'd2, 5'd4, 5'd8, 5'd15, 5'd16, 5'd23,
                                     5'd24, 5'd27, 5'd29, 5'd30, 5'd31});
   assign comp6  = disp_in && (unbal6 || (x == 5'd7));
   assign disp6  = disp_in ^ unbal6;

   // A7 avoids a run of five across the 6b/4b boundary; K.7 always uses it
   assign use_a7 = sym.k || (!disp6 && (x inside {5'd17, 5'd18, 5'd20}))
                         || ( disp6 && (x inside {5'd11, 5'd13, 5'd14}));

   // 3b/4b lookup, RD- column
   always_comb begin
      c4_rdn = 4'b0000;
      unique case (y)
         3'd0: c4_rdn = 4'b1011;
         3'd1: c4_rdn = 4'b1001;
         3'd2: c4_rdn = 4'b0101;
         3'd3: c4_rdn = 4'b1100;
         3'd4: c4_rdn = 4'b1101;
         3'd5: c4_rdn = 4'b1010;
         3'd6: c4_rdn = 4'b0110;
         3'd7: c4_rdn = use_a7 ? 4'b0111 : 4'b1110;
         default: c4_rdn = 4'b0000;
      endcase
   end

   assign unbal4 = (y == 3'd0) || (y == 3'd4) || (y == 3'd7);

   // K28 inverts the neutral 4b codes so the comma keeps its alternate form
   always_comb begin
      comp4 = disp6 && (unbal4 || (y == 3'd3));
      if (k28 && !unbal4 && (y != 3'd3)) comp4 = !disp6;
   end

   assign c6       = comp6 ? ~c6_rdn : c6_rdn;
   assign c4       = comp4 ? ~c4_rdn : c4_rdn;
   assign disp_out = disp6 ^ unbal4;
   assign code     = {c4[0], c4[1], c4[2], c4[3], c6[0], c6[1], c6[2], c6[3], c6[4], c6[5]};

   assign illegal_k = sym.k && !(k28 || ((y == 3'd7) && (x inside {5'd23, 5'd27, 5'd29, 5'd30})));

endmodule

// File: rtl/encode_8b10b_multi.sv
// Registered NUM_BYTES-lane 8b/10b encoder with valid/ready handshake,
// disparity chained across lanes and words, and a saturating illegal-K counter.
// Build option: define ENC8B10B_IDLE_EN to fill idle cycles with K28.5 words.
module encode_8b10b_multi
   import enc8b10b_pkg::*;
#(
   parameter int unsigned NUM_BYTES = 2,
   parameter logic        RST_DISP  = 1'b0,
   parameter int unsigned ERR_CNT_W = 16
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [BYTE_W*NUM_BYTES-1:0]  datain,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [SYM_W*NUM_BYTES-1:0]   dataout,
   output logic [NUM_BYTES-1:0]         err_k,
   output logic                         disp,
   output logic [ERR_CNT_W-1:0]         err_cnt,
   input  logic                         err_clr
);

   logic                        xfer;
   logic [BYTE_W*NUM_BYTES-1:0] enc_in;
   logic [SYM_W*NUM_BYTES-1:0]  enc_code;
   logic [NUM_BYTES-1:0]        enc_illegal;
   logic [NUM_BYTES:0]          chain;
   logic [3:0]                  err_add;
   logic [ERR_CNT_W+3:0]        err_sum;

   assign in_ready = !out_valid || out_ready;
   assign xfer     = in_valid && in_ready;

`ifdef ENC8B10B_IDLE_EN
   assign enc_in = xfer ? datain : {NUM_BYTES{K28_5}};
`else
   assign enc_in = datain;
`endif

   assign chain[0] = disp;

   for (genvar i = 0; i < NUM_BYTES; i++) begin : g_lane
      enc8b10b_lane u_lane (
         .sym       (enc_in[i*BYTE_W +: BYTE_W]),
         .disp_in   (chain[i]),
         .code      (enc_code[i*SYM_W +: SYM_W]),
         .disp_out  (chain[i+1]),
         .illegal_k (enc_illegal[i])
      );
   end

   // Number of illegal-K lanes in the word being offered
   always_comb begin
      err_add = 4'd0;
      for (int i = 0; i < NUM_BYTES; i++) begin
         err_add = err_add + {3'd0, enc_illegal[i]};
      end
   end

   assign err_sum = {4'd0, err_cnt} + {{ERR_CNT_W{1'b0}}, err_add};

   // Output register: load on transfer, hold under backpressure, drain or idle otherwise
   always_ff @(posedge clk) begin
      if (!rst) begin
         out_valid <= 1'b0;
         dataout   <= '0;
         err_k     <= '0;
         disp      <= RST_DISP;
      end else if (xfer) begin
         out_valid <= 1'b1;
         dataout   <= enc_code;
         err_k     <= enc_illegal;
         disp      <= chain[NUM_BYTES];
`ifdef ENC8B10B_IDLE_EN
      end else if (out_ready || !out_valid) begin
         out_valid <= 1'b1;
         dataout   <= enc_code;
         err_k     <= '0;
         disp      <= chain[NUM_BYTES];
`else
      end else if (out_ready) begin
         out_valid <= 1'b0;
`endif
      end
   end

   // Saturating illegal-K counter; clear wins over a same-cycle increment
   always_ff @(posedge clk) begin
      if (!rst) begin
         err_cnt <= '0;
      end else if (err_clr) begin
         err_cnt <= '0;
      end else if (xfer) begin
         if (err_sum[ERR_CNT_W+3:ERR_CNT_W] != 4'd0) err_cnt <= '1;
         else                                        err_cnt <= err_sum[ERR_CNT_W-1:0];
      end
   end

endmodule

// File: doc/encode_8b10b_multi.md
Name: encode_8b10b_multi

Overview:
Registered, parametrised 8b/10b encoder (Widmer/Franaszek) for NUM_BYTES bytes per cycle.
- Running disparity is chained across the byte lanes within a word and carried between words.
- Adds a valid/ready handshake with backpressure, per-lane illegal-K flags and a saturating error counter.
- Sits between the framing logic and the serializer/gearbox in the link transmit path.

Parameters:
NUM_BYTES, 2, byte lanes encoded per cycle (1..8)
RST_DISP, 0, running disparity after reset (0 = RD-, 1 = RD+)
ERR_CNT_W, 16, width of the illegal-K error counter

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-low reset
in_valid  in  1  input word valid
in_ready  out  1  block can accept a word this cycle
datain  in  9*NUM_BYTES  per lane {k, d[7:0]}; lane 0 in bits [8:0]
out_valid  out  1  dataout holds an encoded word
out_ready  in  1  downstream accepts dataout
dataout  out  10*NUM_BYTES  per lane {j,h,g,f,i,e,d,c,b,a}; lane 0 in bits [9:0], a = bit 0
err_k  out  NUM_BYTES  registered with dataout; lane carried k=1 with a non-legal K code
disp  out  1  current running disparity (1 = RD+)
err_cnt  out  ERR_CNT_W  saturating count of illegal-K lanes accepted
err_clr  in  1  synchronous clear of err_cnt

Behaviour:
- Reset: rst is sampled low at a clk edge.
  - out_valid=0, dataout=0, err_k=0, err_cnt=0, disp=RST_DISP.
  - Reset mid-transfer discards the held word.
- Handshake:
  - in_ready = !out_valid | out_ready (combinational).
  - A transfer occurs when in_valid & in_ready.
  - On a transfer, next cycle out_valid=1 and dataout/err_k hold the encoded word. Latency is 1 cycle.
  - With no transfer and out_ready=1, out_valid goes to 0.
  - While out_valid & !out_ready: dataout, err_k and disp hold stable and in_ready=0.
- Disparity chaining:
  - Lane 0 encodes using the disp register.
  - Lane i encodes using the disparity out of lane i-1.
  - On a transfer, disp <= disparity out of lane NUM_BYTES-1. disp changes only on transfers.
- Per-lane encode:
  - Standard 5b/6b and 3b/4b with complement on disparity.
  - Dx.A7 alternate selected per the lane's incoming disparity.
  - Legal K codes: K28.0-.7, K23.7, K27.7, K29.7, K30.7.
  - An illegal K is still encoded by the normal equations; err_k[i]=1.
- err_cnt:
  - On a transfer, adds popcount(illegal lanes) and saturates at all-ones (no wrap).
  - err_clr has priority: clears the counter; illegal lanes in the same cycle are dropped.

Optional Feature:
Macro ENC8B10B_IDLE_EN.
- Defined:
  - When out_ready=1 and no transfer occurs, the block emits an idle word instead of deasserting out_valid.
  - Idle word: every lane K28.5, encoded with normal disparity chaining; disp updates.
  - out_valid=1 from the first cycle after reset release; err_k=0 for idle words.
  - in_ready is unchanged.
- Undefined: out_valid drops when idle as described in Behaviour.

Decomposition:
- Package enc8b10b_pkg:
  - constants K28_5 (9'h1BC), SYM_W=10, BYTE_W=9
  - encoded K28.5 values RD- 10'h17C and RD+ 10'h283
  - typedef for the lane symbol
- Sub-module enc8b10b_lane: purely combinational (datain[8:0], disp_in -> code[9:0], disp_out, illegal_k), instantiated NUM_BYTES times in a generate chain.
- Top module: handshake register, disp register, err_cnt, idle mux.

Test Plan:
- Reset, RST_DISP=0, NUM_BYTES=2; send datain={9'h1BC,9'h1BC} -> next cycle dataout={10'h283,10'h17C}, disp=0, err_k=0.
- Two consecutive words of D21.5 {9'h0B5,9'h0B5} -> every lane 10'h155, disp unchanged both cycles, in_ready stays 1 with out_ready=1.
- Hold out_ready=0 for 3 cycles after a valid word -> dataout/disp frozen, in_ready=0; release -> next word accepted the same cycle.
- Send K1.0 (9'h101) in lane 1 -> err_k=2'b10, err_cnt=1; with ERR_CNT_W=2, repeat 5 times -> err_cnt saturates at 3; err_clr -> 0.
- Random 10k words, random backpressure -> decode model shows no disparity error across word boundaries and no run length >5.
- With ENC8B10B_IDLE_EN, in_valid=0 after reset -> alternating 10'h17C/10'h283 per lane, out_valid=1.
